// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the segment scan controller
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// rtl/seg_scan_ctrl_timer.sv - per-slot cycle counter with blank/slot end flags
module scan_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic blank_end,
    output logic slot_end
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] SLOT_LAST  = TW'(REFRESH_DIV - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == SLOT_LAST) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign blank_end = (count == BLANK_LAST);
    assign slot_end  = (count == SLOT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with double-buffered digit codes
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           load,
    input  logic [CODE_W*NUM_DIGITS-1:0]   value_in,
    output logic [CODE_W-1:0]              dec_code,
    input  logic [SEG_W-1:0]               seg_in,
    output logic [SEG_W-1:0]               seg_out,
    output logic [NUM_DIGITS-1:0]          anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
    output logic                           frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = CODE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state, next_state;
    logic             blank_end, slot_end, timer_clear;
    logic [VAL_W-1:0] active, shadow, active_nxt;
    logic             pending;
    logic             commit;
    logic [IDX_W-1:0] idx_nxt;

    assign timer_clear = (state == IDLE) || !enable;

    scan_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = BLANK;
                BLANK:   if (blank_end) next_state = SHOW;
                SHOW:    if (slot_end) next_state = BLANK;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        anode_n    = '1;
        frame_done = 1'b0;
        if (state == SHOW) begin
            anode_n[digit_idx] = 1'b0;
            frame_done         = slot_end && enable && (digit_idx == LAST_DIGIT);
        end
    end

    // Active codes only change on a frame boundary or when scanning restarts,
    // so a frame is never drawn from two different loads.
    assign commit = frame_done || (state == IDLE && enable);

    always_comb begin
        active_nxt = active;
        if (commit) begin
            if (load) begin
                active_nxt = value_in;
            end else if (pending) begin
                active_nxt = shadow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            active <= active_nxt;
            if (load) begin
                shadow <= value_in;
            end
            if (commit) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        idx_nxt = digit_idx;
        if (next_state == IDLE) begin
            idx_nxt = '0;
        end else if (state == SHOW && slot_end) begin
            idx_nxt = (digit_idx == LAST_DIGIT) ? '0 : digit_idx + IDX_W'(1);
        end
    end

    // dec_code is set on slot entry so the decoder settles during blanking;
    // seg_out is aligned with the anode by looking at the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_idx <= '0;
            dec_code  <= '0;
            seg_out   <= SEG_OFF;
        end else begin
            digit_idx <= idx_nxt;
            if (next_state == BLANK && state != BLANK) begin
                dec_code <= active_nxt[CODE_W*idx_nxt +: CODE_W];
            end
            seg_out <= (next_state == SHOW) ? seg_in : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
    import seg_scan_pkg::*;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int FRAME = N * R;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [19:0] value_in;
    logic [4:0]  dec_code;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  anode_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value_in   (value_in),
        .dec_code   (dec_code),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .anode_n    (anode_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] dec7(input logic [4:0] c);
        case (c)
            5'h00: dec7 = 7'h3F;
            5'h01: dec7 = 7'h06;
            5'h02: dec7 = 7'h5B;
            5'h03: dec7 = 7'h4F;
            5'h04: dec7 = 7'h66;
            5'h05: dec7 = 7'h6D;
            5'h06: dec7 = 7'h7D;
            5'h07: dec7 = 7'h07;
            5'h08: dec7 = 7'h7F;
            5'h09: dec7 = 7'h6F;
            5'h0A: dec7 = 7'h77;
            5'h0B: dec7 = 7'h7C;
            5'h0C: dec7 = 7'h39;
            5'h0D: dec7 = 7'h5E;
            5'h0E: dec7 = 7'h79;
            5'h0F: dec7 = 7'h71;
            default: dec7 = {c[0], c[1], c[2], c[3], c[4], 2'b01};
        endcase
    endfunction

    always_comb seg_in = dec7(dec_code);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position within a frame plus the buffered digit arrays.
    logic [4:0] m_act[N];
    logic [4:0] m_sh[N];
    bit         m_pend;
    bit         m_run;
    int         m_pos;
    logic [4:0] m_last_dec;
    logic       cur_en, cur_ld;
    logic [19:0] cur_v;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_act[k] = '0;
            m_sh[k]  = '0;
        end
        m_pend = 0;
        m_run = 0;
        m_pos = 0;
        m_last_dec = '0;
    endtask

    task automatic model_step(input logic en, input logic ld, input logic [19:0] v);
        logic [4:0] vd[N];
        bit commit;
        for (int k = 0; k < N; k++) vd[k] = v[5*k +: 5];
        if (m_run) m_last_dec = m_act[m_pos / R];
        commit = en && (!m_run || m_pos == FRAME - 1);
        if (!en) begin
            m_run = 0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        if (commit) begin
            if (ld) begin
                m_act = vd;
                m_sh = vd;
                m_pend = 0;
            end else if (m_pend) begin
                m_act = m_sh;
                m_pend = 0;
            end
        end else if (ld) begin
            m_sh = vd;
            m_pend = 1;
        end
    endtask

    task automatic check_model();
        int d, ph;
        logic [3:0] ea, low;
        logic [6:0] es;
        low = ~anode_n;
        chk("anode_onehot", ($countones(low) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (!m_run) begin
            chk("idle_anode", anode_n, 4'hF);
            chk("idle_seg", seg_out, SEG_OFF);
            chk("idle_idx", digit_idx, 0);
            chk("idle_fd", frame_done, 0);
            chk("idle_dec", dec_code, m_last_dec);
        end else begin
            d = m_pos / R;
            ph = m_pos % R;
            ea = 4'hF;
            es = SEG_OFF;
            if (ph >= B) begin
                ea[d] = 1'b0;
                es = dec7(m_act[d]);
            end
            chk("anode", anode_n, ea);
            chk("seg", seg_out, es);
            chk("idx", digit_idx, d);
            chk("dec", dec_code, m_act[d]);
            chk("fd", frame_done, (m_pos == FRAME - 1 && cur_en) ? 1 : 0);
        end
    endtask

    task automatic drive_sample(input logic en, input logic ld, input logic [19:0] v);
        @(negedge clk);
        enable = en;
        load = ld;
        value_in = v;
        cur_en = en;
        cur_ld = ld;
        cur_v = v;
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(cur_en, cur_ld, cur_v);
    endtask

    task automatic tick(input logic en, input logic ld, input logic [19:0] v);
        drive_sample(en, ld, v);
        advance();
    endtask

    task automatic run_to(input int target);
        bit found = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            if (m_run && m_pos == target) begin
                found = 1;
                break;
            end
            tick(1'b1, 1'b0, 20'($urandom));
        end
        chk("run_to_reached", found, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_anode"}, anode_n, 4'hF);
        chk({tag, "_seg"}, seg_out, 7'h7F);
        chk({tag, "_dec"}, dec_code, 0);
        chk({tag, "_idx"}, digit_idx, 0);
        chk({tag, "_fd"}, frame_done, 0);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] anode;
        logic [4:0] code;
        logic [1:0] idx;
    } slot_vec_t;

    slot_vec_t slot_tbl[N];

    logic [19:0] v1, v2, v3, v4;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        v1 = {5'd0, 5'd1, 5'd2, 5'd4};
        v2 = {5'd9, 5'd7, 5'd3, 5'd5};
        v3 = {5'd12, 5'd11, 5'd10, 5'd6};
        v4 = {5'd17, 5'd14, 5'd13, 5'd19};
        slot_tbl[0] = '{en: 1'b1, anode: 4'hE, code: 5'd4, idx: 2'd0};
        slot_tbl[1] = '{en: 1'b1, anode: 4'hD, code: 5'd2, idx: 2'd1};
        slot_tbl[2] = '{en: 1'b1, anode: 4'hB, code: 5'd1, idx: 2'd2};
        slot_tbl[3] = '{en: 1'b1, anode: 4'h7, code: 5'd0, idx: 2'd3};

        rst = 1'b1;
        enable = 1'b0;
        load = 1'b0;
        value_in = '0;
        cur_en = 0;
        cur_ld = 0;
        cur_v = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic scan: load while idle, then two full frames from the table.
        tick(1'b0, 1'b1, v1);
        tick(1'b1, 1'b0, 20'($urandom));
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < N; s++) begin
                for (int p = 0; p < R; p++) begin
                    drive_sample(slot_tbl[s].en, 1'b0, 20'($urandom));
                    chk("tbl_anode", anode_n, (p < B) ? 4'hF : slot_tbl[s].anode);
                    chk("tbl_seg", seg_out, (p < B) ? 7'h7F : dec7(slot_tbl[s].code));
                    chk("tbl_dec", dec_code, slot_tbl[s].code);
                    chk("tbl_idx", digit_idx, slot_tbl[s].idx);
                    chk("tbl_fd", frame_done, (s == N - 1 && p == R - 1) ? 1 : 0);
                    advance();
                end
            end
        end

        // Mid-frame load waits for the frame boundary.
        run_to(R + 4);
        tick(1'b1, 1'b1, v2);
        run_to(FRAME - 1);
        drive_sample(1'b1, 1'b0, 20'($urandom));
        chk("old_code_before_boundary", dec_code, v1[19:15]);
        advance();
        drive_sample(1'b1, 1'b0, 20'($urandom));
        chk("new_code_after_boundary", dec_code, v2[4:0]);
        advance();

        // Load on the frame_done cycle goes straight to the active set.
        run_to(FRAME - 1);
        drive_sample(1'b1, 1'b1, v3);
        chk("fd_at_direct_load", frame_done, 1);
        advance();
        drive_sample(1'b1, 1'b0, 20'($urandom));
        chk("direct_load_code", dec_code, v3[4:0]);
        advance();

        // Enable dropped while digit 2 shows, load while idle, re-enable.
        run_to(2 * R + 3);
        tick(1'b0, 1'b0, 20'($urandom));
        drive_sample(1'b0, 1'b1, v4);
        chk("dis_anode", anode_n, 4'hF);
        chk("dis_seg", seg_out, 7'h7F);
        chk("dis_idx", digit_idx, 0);
        advance();
        tick(1'b0, 1'b0, 20'($urandom));
        tick(1'b1, 1'b0, 20'($urandom));
        drive_sample(1'b1, 1'b0, 20'($urandom));
        chk("reen_anode", anode_n, 4'hF);
        chk("reen_code", dec_code, v4[4:0]);
        chk("reen_idx", digit_idx, 0);
        advance();

        // Asynchronous reset between edges while showing.
        run_to(R + 5);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        cur_en = 0;
        cur_ld = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1'b1, 1'b0, 20'($urandom));
        drive_sample(1'b1, 1'b0, 20'($urandom));
        chk("post_rst_code", dec_code, 0);
        advance();

        // All digits at code 1F.
        tick(1'b1, 1'b1, {4{5'h1F}});
        for (int i = 0; i < 3 * FRAME; i++) tick(1'b1, 1'b0, 20'($urandom));
        run_to(R + 3);
        drive_sample(1'b1, 1'b0, 20'($urandom));
        chk("all1f_seg", seg_out, dec7(5'h1F));
        advance();

        // Randomised traffic against the model.
        for (int i = 0; i < 1200; i++) begin
            tick(($urandom % 20) != 0, ($urandom % 12) == 0, 20'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
